// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared state encoding and instruction field layout for the
//               fetch sequencer and the instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INS_W   = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 9;
    localparam int R1_MSB  = 8;
    localparam int R1_LSB  = 6;
    localparam int R2_MSB  = 5;
    localparam int R2_LSB  = 3;
    localparam int R3_MSB  = 2;
    localparam int R3_LSB  = 0;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    function automatic logic [OP_MSB-OP_LSB:0] op_field(input logic [INS_W-1:0] ins);
        return ins[OP_MSB:OP_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Program counter, one-per-cycle instruction fetch and issue
//               register with valid/ready handoff to execute.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [6:0] HALT_OP   = 7'h7F,
    parameter bit         WRAP_HALT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic              Stop,
    output logic [ADDR_W-1:0] Addr,
    input  logic [INS_W-1:0]  Ins,
    output logic              IssueValid,
    input  logic              IssueReady,
    output logic [INS_W-1:0]  IssueIns,
    output logic [ADDR_W-1:0] IssuePc,
    output logic [6:0]        OpCode,
    output logic [2:0]        R1,
    output logic [2:0]        R2,
    output logic [2:0]        R3,
    output logic [5:0]        Imm6,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectAddr,
    output logic              Busy,
    output logic              Halted,
    output logic [15:0]       InsCount
);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   pc, pc_d;
    logic                issue_valid, valid_d;
    logic [INS_W-1:0]    issue_ins, ins_d;
    logic [ADDR_W-1:0]   issue_pc, ipc_d;
    logic [15:0]         ins_count, cnt_d;

    logic                handshake;
    logic                fetch_halt;
    logic [15:0]         cnt_inc;
    logic                do_fetch;

    assign handshake  = issue_valid && IssueReady;
    assign fetch_halt = (op_field(Ins) == HALT_OP);
    assign cnt_inc    = (ins_count == 16'hFFFF) ? ins_count : ins_count + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            issue_valid <= 1'b0;
            issue_ins   <= '0;
            issue_pc    <= '0;
            ins_count   <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            issue_valid <= valid_d;
            issue_ins   <= ins_d;
            issue_pc    <= ipc_d;
            ins_count   <= cnt_d;
        end
    end

    // Priority: Stop > Redirect > handshake/fetch > Start
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        valid_d  = issue_valid;
        ins_d    = issue_ins;
        ipc_d    = issue_pc;
        cnt_d    = ins_count;
        do_fetch = 1'b0;
        if (Stop) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (Start) begin
                        pc_d    = StartAddr;
                        cnt_d   = '0;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (Redirect) begin
                        pc_d    = RedirectAddr;
                        valid_d = 1'b0;
                    end else begin
                        do_fetch = 1'b1;
                    end
                end
                ISSUE: begin
                    // A branch accepted alongside its redirect still counts as issued
                    if (handshake) cnt_d = cnt_inc;
                    if (Redirect) begin
                        pc_d    = RedirectAddr;
                        valid_d = 1'b0;
                        state_d = FETCH;
                    end else if (handshake) begin
                        if (WRAP_HALT && issue_pc == {ADDR_W{1'b1}}) begin
                            valid_d = 1'b0;
                            state_d = HALT;
                        end else begin
                            do_fetch = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (do_fetch) begin
                if (fetch_halt) begin
                    valid_d = 1'b0;
                    state_d = HALT;
                end else begin
                    ins_d   = Ins;
                    ipc_d   = pc;
                    pc_d    = pc + 8'd1;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
        end
    end

    always_comb begin
        Busy   = (state == FETCH) || (state == ISSUE);
        Halted = (state == HALT);
    end

    assign Addr       = pc;
    assign IssueValid = issue_valid;
    assign IssueIns   = issue_ins;
    assign IssuePc    = issue_pc;
    assign InsCount   = ins_count;
    assign OpCode     = issue_ins[OP_MSB:OP_LSB];
    assign R1         = issue_ins[R1_MSB:R1_LSB];
    assign R2         = issue_ins[R2_MSB:R2_LSB];
    assign R3         = issue_ins[R3_MSB:R3_LSB];
    assign Imm6       = issue_ins[IMM_MSB:IMM_LSB];

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed bench for fetch_sequencer, both wrap modes, with a
//               behavioural 256x16 instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start, Stop, IssueReady, Redirect;
    logic [7:0]  StartAddr, RedirectAddr;

    logic [15:0] mem [256];

    logic [7:0]  addr0, ipc0, addr1, ipc1;
    logic [15:0] ins0, iins0, cnt0, ins1, iins1, cnt1;
    logic        val0, busy0, halt0, val1, busy1, halt1;
    logic [6:0]  op0, op1;
    logic [2:0]  r1_0, r2_0, r3_0, r1_1, r2_1, r3_1;
    logic [5:0]  imm0, imm1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign ins0 = mem[addr0];
    assign ins1 = mem[addr1];

    fetch_sequencer #(.HALT_OP(7'h7F), .WRAP_HALT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Start(Start), .StartAddr(StartAddr), .Stop(Stop),
        .Addr(addr0), .Ins(ins0), .IssueValid(val0), .IssueReady(IssueReady),
        .IssueIns(iins0), .IssuePc(ipc0), .OpCode(op0), .R1(r1_0), .R2(r2_0), .R3(r3_0),
        .Imm6(imm0), .Redirect(Redirect), .RedirectAddr(RedirectAddr),
        .Busy(busy0), .Halted(halt0), .InsCount(cnt0)
    );

    fetch_sequencer #(.HALT_OP(7'h7F), .WRAP_HALT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Start(Start), .StartAddr(StartAddr), .Stop(Stop),
        .Addr(addr1), .Ins(ins1), .IssueValid(val1), .IssueReady(IssueReady),
        .IssueIns(iins1), .IssuePc(ipc1), .OpCode(op1), .R1(r1_1), .R2(r2_1), .R3(r3_1),
        .Imm6(imm1), .Redirect(Redirect), .RedirectAddr(RedirectAddr),
        .Busy(busy1), .Halted(halt1), .InsCount(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem[0] = 16'h0000;
        mem[1] = 16'h0678;
        mem[2] = 16'h0803;
        for (int i = 3; i < 256; i++) mem[i] = 16'h020A;

        rst_n = 1'b0; Start = 1'b0; Stop = 1'b0; IssueReady = 1'b0; Redirect = 1'b0;
        StartAddr = 8'h00; RedirectAddr = 8'h00;
        #12;
        check("rst_valid", val0, 0);
        check("rst_addr", addr0, 0);
        check("rst_count", cnt0, 0);
        check("rst_busy", busy0, 0);
        check("rst_halted", halt0, 0);
        check("rst_ins", iins0, 0);
        rst_n = 1'b1;
        tick();

        // Stream from address 1
        Start = 1'b1; StartAddr = 8'h01; IssueReady = 1'b1;
        tick();
        Start = 1'b0;
        check("s1_busy", busy0, 1);
        check("s1_valid", val0, 0);
        check("s1_addr", addr0, 8'h01);
        tick();
        check("s2_valid", val0, 1);
        check("s2_ins", iins0, 16'h0678);
        check("s2_pc", ipc0, 8'h01);
        check("s2_op", op0, 3);
        check("s2_r1", r1_0, 1);
        check("s2_r2", r2_0, 7);
        check("s2_cnt", cnt0, 0);
        tick();
        check("s3_ins", iins0, 16'h0803);
        check("s3_op", op0, 4);
        check("s3_imm", imm0, 3);
        check("s3_cnt", cnt0, 1);

        // Backpressure holding 0803
        IssueReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_ins", iins0, 16'h0803);
            check("bp_pc", ipc0, 8'h02);
            check("bp_addr", addr0, 8'h03);
            check("bp_cnt", cnt0, 1);
        end
        IssueReady = 1'b1;
        tick();
        check("rel_ins", iins0, 16'h020A);
        check("rel_op", op0, 1);
        check("rel_cnt", cnt0, 2);
        tick();
        tick();
        check("pre_redir_pc", ipc0, 8'h05);
        check("pre_redir_cnt", cnt0, 4);

        // Redirect from PC 5 to 2 with concurrent accept
        Redirect = 1'b1; RedirectAddr = 8'h02;
        tick();
        Redirect = 1'b0;
        check("redir_valid", val0, 0);
        check("redir_addr", addr0, 8'h02);
        check("redir_cnt", cnt0, 5);
        tick();
        check("redir_ins", iins0, 16'h0803);
        check("redir_pc", ipc0, 8'h02);
        check("redir_cnt2", cnt0, 5);

        // Stop mid-stream
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        check("stop_busy", busy0, 0);
        check("stop_valid", val0, 0);
        check("stop_addr", addr0, 8'h03);
        check("stop_cnt", cnt0, 5);
        check("stop_ins", iins0, 16'h0803);

        // Halt opcode at address 4
        mem[4] = 16'hFE00;
        Start = 1'b1; StartAddr = 8'h01; IssueReady = 1'b1;
        tick();
        Start = 1'b0;
        check("h_cnt0", cnt0, 0);
        tick();
        check("h_pc1", ipc0, 8'h01);
        tick();
        check("h_pc2", ipc0, 8'h02);
        tick();
        check("h_pc3", ipc0, 8'h03);
        tick();
        check("h_halted", halt0, 1);
        check("h_valid", val0, 0);
        check("h_busy", busy0, 0);
        check("h_cnt", cnt0, 3);
        check("h_addr", addr0, 8'h04);
        tick();
        check("h_hold", halt0, 1);
        check("h_hold_valid", val0, 0);
        Start = 1'b1; StartAddr = 8'h00;
        tick();
        Start = 1'b0; IssueReady = 1'b0;
        check("rs_halted", halt0, 0);
        check("rs_busy", busy0, 1);
        check("rs_cnt", cnt0, 0);
        check("rs_addr", addr0, 8'h00);
        tick();
        check("rs_valid", val0, 1);
        check("rs_pc", ipc0, 8'h00);
        check("rs_ins", iins0, 16'h0000);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        mem[4] = 16'h020A;

        // Wrap at FF in both modes
        Start = 1'b1; StartAddr = 8'hFE; IssueReady = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        check("w_pc_fe0", ipc0, 8'hFE);
        check("w_pc_fe1", ipc1, 8'hFE);
        tick();
        check("w_pc_ff0", ipc0, 8'hFF);
        check("w_pc_ff1", ipc1, 8'hFF);
        tick();
        check("w_pc_000", ipc0, 8'h00);
        check("w_valid0", val0, 1);
        check("w_cnt0", cnt0, 2);
        check("w_halt1", halt1, 1);
        check("w_valid1", val1, 0);
        check("w_cnt1", cnt1, 2);

        // Asynchronous reset between edges while dut0 is issuing
        IssueReady = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", val0, 0);
        check("ar_addr", addr0, 0);
        check("ar_ins", iins0, 0);
        check("ar_pc", ipc0, 0);
        check("ar_cnt", cnt0, 0);
        check("ar_busy", busy0, 0);
        check("ar_halted1", halt1, 0);
        #3;
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the 256 x 16-bit instruction memory (8-bit Addr, combinational read Ins) for the single-cycle datapath.
- Owns the program counter, fetches one instruction per cycle, and holds it in an issue register.
- Hands the instruction to execute over a valid/ready handshake.
- Handles start/stop, taken-branch redirects from execute, and a halt opcode.

Parameters:
- HALT_OP, 7'h7F, opcode value (Ins[15:9]) that stops sequencing; the halt word is never issued.
- WRAP_HALT, 0, if 1, reaching PC 8'hFF and consuming that instruction enters HALT instead of wrapping to 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Start  in  1  begin sequencing at StartAddr (honoured only in IDLE or HALT)
- StartAddr  in  8  first fetch address
- Stop  in  1  abort to IDLE from any state
- Addr  out  8  instruction memory address; always equals PC
- Ins  in  16  instruction memory read data (combinational from Addr)
- IssueValid  out  1  issue register holds a valid instruction
- IssueReady  in  1  execute accepts the instruction this cycle
- IssueIns  out  16  held instruction
- IssuePc  out  8  address of held instruction
- OpCode  out  7  IssueIns[15:9]
- R1  out  3  IssueIns[8:6]
- R2  out  3  IssueIns[5:3]
- R3  out  3  IssueIns[2:0]
- Imm6  out  6  IssueIns[5:0], zero-extended by the consumer
- Redirect  in  1  taken branch: discard the held instruction, resume at RedirectAddr
- RedirectAddr  in  8  branch target
- Busy  out  1  state is FETCH or ISSUE
- Halted  out  1  state is HALT
- InsCount  out  16  count of completed handshakes since Start, saturating at 16'hFFFF

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, PC=0, IssueValid=0, IssueIns=0, IssuePc=0, InsCount=0.
  - Busy=0, Halted=0.
- Decoded field outputs are combinational slices of IssueIns.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: on Start, PC<=StartAddr, InsCount<=0, go to FETCH. Otherwise hold.
- FETCH: Ins is sampled for Addr=PC.
  - If Ins[15:9]==HALT_OP: go to HALT, IssueValid stays 0, PC unchanged.
  - Else: IssueIns<=Ins, IssuePc<=PC, IssueValid<=1, PC<=PC+1 (mod 256), go to ISSUE.
  - Latency from Start to first IssueValid is 2 cycles.
- ISSUE, no handshake (IssueValid=1 and IssueReady=0): hold all registers stable.
- ISSUE, handshake (IssueValid and IssueReady): InsCount increments, then the next instruction is fetched from Addr=PC in the same cycle.
  - Throughput is 1 instruction per cycle while IssueReady=1.
  - Halt word fetched: IssueValid<=0, go to HALT.
  - Normal word: load the issue register as in FETCH and stay in ISSUE.
- Wrap, WRAP_HALT=1: a handshake with IssuePc==8'hFF goes to HALT with no further fetch.
- Wrap, WRAP_HALT=0: PC wraps 8'hFF to 8'h00.
- Redirect (FETCH or ISSUE), which beats handshake and fetch:
  - PC<=RedirectAddr, IssueValid<=0, go to FETCH.
  - A concurrent IssueReady still counts the held instruction in InsCount; that instruction is the branch's own issue slot, already consumed by execute.
  - Redirect in IDLE or HALT is ignored.
- Stop beats Redirect and Start:
  - Go to IDLE, IssueValid<=0.
  - PC, InsCount and IssueIns are retained.
- HALT: hold. Start behaves as in IDLE (restart). Halted=1.
- Start while Busy is ignored.
- Priority summary: Stop > Redirect > handshake/fetch > Start.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum: IDLE, FETCH, ISSUE, HALT
  - field position constants: OP_MSB=15, OP_LSB=9, R1 8:6, R2 5:3, R3 2:0, IMM 5:0
  - width constants: ADDR_W=8, INS_W=16
- Instruction field decode is shared with the decoder.
- No sub-module. The issue register plus decode slices stay inline. The bench instantiates the existing instruction memory next to it.

Test Plan:
- Memory image: [0]=16'h0000, [1]=16'h0678, [2]=16'h0803, [3..]=16'h020A style opcode-1 words. Start with StartAddr=1 and IssueReady=1 -> IssueValid rises cycle 2 with IssueIns=16'h0678 and IssuePc=1, then 16'h0803 and 16'h020A on consecutive cycles. OpCode=3/4/1, R1=1 and R2=7 for the first word, Imm6=3 for the second.
- Backpressure: IssueReady=0 for 3 cycles while holding 16'h0803 -> IssueIns, IssuePc and Addr=3 stable, InsCount unchanged. Release -> exactly one increment per accepted word.
- Redirect with IssueReady=1 while IssuePc=5, RedirectAddr=2 -> next IssueValid=0, Addr=2, then IssueIns=16'h0803 and IssuePc=2. InsCount includes PC 5 but not PC 6.
- HALT_OP word (16'hFE00) at address 4, start at 1 -> PCs 1, 2, 3 issued, Halted=1, IssueValid=0, word at 4 never issued. Start with StartAddr=0 -> restart, InsCount=0.
- Wrap: StartAddr=8'hFE with WRAP_HALT=0 -> IssuePc FE, FF, 00. With WRAP_HALT=1 -> HALT after FF is accepted.
- Reset asserted mid-ISSUE, async, between clock edges -> all outputs return to reset values immediately. Stop mid-stream -> IDLE with PC retained.
